// File: rtl/quad_pe_feeder.sv
// Feeds a Quad_PE: streams packed IFM/weight words from two synchronous buffers
// onto the PE operand ports, closes each dot product with PE_finish, and waits for ofm_valid.

module quad_pe_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] ifm_i,
  input  logic [DATA_W-1:0] wgt_i,
  output logic [DATA_W-1:0] ifm_o,
  output logic [DATA_W-1:0] wgt_o
);
  logic [DATA_W-1:0] ifm_q, wgt_q;

  // Operands are forced to zero whenever the PE is not enabled.
  always_ff @(posedge clk) begin
    if (reset_n || !load_i) begin
      ifm_q <= '0;
      wgt_q <= '0;
    end else begin
      ifm_q <= ifm_i;
      wgt_q <= wgt_i;
    end
  end

  assign ifm_o = ifm_q;
  assign wgt_o = wgt_q;
endmodule

module quad_pe_feeder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   ifm_base,
  input  logic [ADDR_W-1:0]   wgt_base,
  input  logic [CNT_W-1:0]    num_groups,
  input  logic [CNT_W-1:0]    num_outputs,
  output logic                ifm_rd_en,
  output logic                wgt_rd_en,
  output logic [ADDR_W-1:0]   ifm_rd_addr,
  output logic [ADDR_W-1:0]   wgt_rd_addr,
  input  logic [4*DATA_W-1:0] ifm_rd_data,
  input  logic [4*DATA_W-1:0] wgt_rd_data,
  output logic [DATA_W-1:0]   IFM1,
  output logic [DATA_W-1:0]   IFM2,
  output logic [DATA_W-1:0]   IFM3,
  output logic [DATA_W-1:0]   IFM4,
  output logic [DATA_W-1:0]   Weight1,
  output logic [DATA_W-1:0]   Weight2,
  output logic [DATA_W-1:0]   Weight3,
  output logic [DATA_W-1:0]   Weight4,
  output logic                PE_en,
  output logic                PE_finish,
  input  logic                ofm_valid,
  output logic                busy,
  output logic                done
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, FINISH, WAIT_OFM} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  g_q, n_q, k_q, o_q;
  logic [ADDR_W-1:0] wgt_base_q, ifm_addr_q, wgt_addr_q;
  logic              rd_en_q, drain_q, finish_q, busy_q, done_q;
  logic [1:0]        vld_pipe_q;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= IDLE;
      g_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      o_q        <= '0;
      wgt_base_q <= '0;
      ifm_addr_q <= '0;
      wgt_addr_q <= '0;
      rd_en_q    <= 1'b0;
      drain_q    <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (num_groups != '0 && num_outputs != '0) begin
            g_q        <= num_groups;
            n_q        <= num_outputs;
            wgt_base_q <= wgt_base;
            ifm_addr_q <= ifm_base;
            wgt_addr_q <= wgt_base;
            k_q        <= '0;
            o_q        <= '0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= READ;
          end else begin
            done_q <= 1'b1;
          end
        end
        READ: if (k_q == g_q - CNT_W'(1)) begin
          rd_en_q <= 1'b0;
          drain_q <= 1'b0;
          state_q <= DRAIN;
        end else begin
          k_q        <= k_q + CNT_W'(1);
          ifm_addr_q <= ifm_addr_q + ADDR_W'(1);
          wgt_addr_q <= wgt_addr_q + ADDR_W'(1);
        end
        DRAIN: if (drain_q) begin
          finish_q <= 1'b1;
          state_q  <= FINISH;
        end else begin
          drain_q <= 1'b1;
        end
        FINISH: begin
          finish_q <= 1'b0;
          state_q  <= WAIT_OFM;
        end
        WAIT_OFM: if (ofm_valid) begin
          if (o_q == n_q - CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            // IFM words of consecutive outputs are contiguous, so the running address just advances.
            o_q        <= o_q + CNT_W'(1);
            k_q        <= '0;
            ifm_addr_q <= ifm_addr_q + ADDR_W'(1);
            wgt_addr_q <= wgt_base_q;
            rd_en_q    <= 1'b1;
            state_q    <= READ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // [0]: read data present on the buffer bus, [1]: operands registered at the PE.
  always_ff @(posedge clk) begin
    if (reset_n) vld_pipe_q <= '0;
    else         vld_pipe_q <= {vld_pipe_q[0], rd_en_q};
  end

  logic [NUM_LANES-1:0][DATA_W-1:0] ifm_lane, wgt_lane;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    quad_pe_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (vld_pipe_q[0]),
      .ifm_i   (ifm_rd_data[l*DATA_W +: DATA_W]),
      .wgt_i   (wgt_rd_data[l*DATA_W +: DATA_W]),
      .ifm_o   (ifm_lane[l]),
      .wgt_o   (wgt_lane[l])
    );
  end

  assign ifm_rd_en   = rd_en_q;
  assign wgt_rd_en   = rd_en_q;
  assign ifm_rd_addr = ifm_addr_q;
  assign wgt_rd_addr = wgt_addr_q;
  assign IFM1    = ifm_lane[0];
  assign IFM2    = ifm_lane[1];
  assign IFM3    = ifm_lane[2];
  assign IFM4    = ifm_lane[3];
  assign Weight1 = wgt_lane[0];
  assign Weight2 = wgt_lane[1];
  assign Weight3 = wgt_lane[2];
  assign Weight4 = wgt_lane[3];
  assign PE_en     = vld_pipe_q[1];
  assign PE_finish = finish_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_quad_pe_feeder.sv
// Scoreboard bench for quad_pe_feeder: directed plan items plus randomized jobs,
// with expected reads and PE operands generated from the job parameters.

module tb_quad_pe_feeder;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n, start, ofm_valid;
  logic [ADDR_W-1:0]   ifm_base, wgt_base;
  logic [CNT_W-1:0]    num_groups, num_outputs;
  logic                ifm_rd_en, wgt_rd_en;
  logic [ADDR_W-1:0]   ifm_rd_addr, wgt_rd_addr;
  logic [4*DATA_W-1:0] ifm_rd_data, wgt_rd_data;
  logic [DATA_W-1:0]   IFM1, IFM2, IFM3, IFM4, Weight1, Weight2, Weight3, Weight4;
  logic                PE_en, PE_finish, busy, done;

  quad_pe_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .ifm_base(ifm_base), .wgt_base(wgt_base),
    .num_groups(num_groups), .num_outputs(num_outputs),
    .ifm_rd_en(ifm_rd_en), .wgt_rd_en(wgt_rd_en),
    .ifm_rd_addr(ifm_rd_addr), .wgt_rd_addr(wgt_rd_addr),
    .ifm_rd_data(ifm_rd_data), .wgt_rd_data(wgt_rd_data),
    .IFM1(IFM1), .IFM2(IFM2), .IFM3(IFM3), .IFM4(IFM4),
    .Weight1(Weight1), .Weight2(Weight2), .Weight3(Weight3), .Weight4(Weight4),
    .PE_en(PE_en), .PE_finish(PE_finish), .ofm_valid(ofm_valid),
    .busy(busy), .done(done)
  );

  // Synchronous buffers: data valid the cycle after the strobe.
  logic [31:0] ifm_mem [DEPTH];
  logic [31:0] wgt_mem [DEPTH];
  always @(posedge clk) begin
    if (ifm_rd_en) ifm_rd_data <= ifm_mem[ifm_rd_addr];
    if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
  end

  typedef struct {bit fin; logic [31:0] ifm; logic [31:0] wgt;} pe_exp_t;
  typedef struct {logic [ADDR_W-1:0] ifm; logic [ADDR_W-1:0] wgt;} addr_t;
  pe_exp_t exp_q[$];
  addr_t   addr_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [95:0] act, logic [95:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  logic [DATA_W-1:0] ifm_v [4];
  logic [DATA_W-1:0] wgt_v [4];
  assign ifm_v[0] = IFM1;    assign ifm_v[1] = IFM2;    assign ifm_v[2] = IFM3;    assign ifm_v[3] = IFM4;
  assign wgt_v[0] = Weight1; assign wgt_v[1] = Weight2; assign wgt_v[2] = Weight3; assign wgt_v[3] = Weight4;

  // Monitor: pops the scoreboard whenever the DUT reads or drives the PE.
  initial begin
    pe_exp_t e;
    addr_t   a;
    bit      prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (ifm_rd_en || wgt_rd_en) begin
        if (addr_q.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          a = addr_q.pop_front();
          chk("ifm_rd_addr", ifm_rd_addr, a.ifm);
          chk("wgt_rd_addr", wgt_rd_addr, a.wgt);
          chk("rd_en_pair", {ifm_rd_en, wgt_rd_en}, 2'b11);
        end
      end
      if (PE_en && PE_finish) chk("en_finish_overlap", 1, 0);
      if (PE_en) begin
        if (exp_q.size() == 0) chk("unexpected_pe_en", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pe_en_slot", e.fin, 0);
          for (int n = 0; n < 4; n++) begin
            chk("ifm_elem", ifm_v[n], (e.ifm >> (8 * n)) & 32'hff);
            chk("wgt_elem", wgt_v[n], (e.wgt >> (8 * n)) & 32'hff);
          end
        end
      end else if ({IFM1, IFM2, IFM3, IFM4, Weight1, Weight2, Weight3, Weight4} != '0) begin
        chk("operands_idle_zero", {IFM1, IFM2, IFM3, IFM4, Weight1, Weight2, Weight3, Weight4}, 0);
      end
      if (PE_finish) begin
        if (exp_q.size() == 0) chk("unexpected_finish", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("finish_slot", e.fin, 1);
          chk("finish_after_en", prev_en, 1);
        end
      end
      prev_en = PE_en;
    end
  end

  // Reference model: the read and operand streams a job must produce.
  task automatic push_job(int ib, int wb, int g, int n);
    int ia, wa;
    for (int o = 0; o < n; o++) begin
      for (int k = 0; k < g; k++) begin
        ia = (ib + o * g + k) % DEPTH;
        wa = (wb + k) % DEPTH;
        addr_q.push_back('{ifm: ADDR_W'(ia), wgt: ADDR_W'(wa)});
        exp_q.push_back('{fin: 1'b0, ifm: ifm_mem[ia], wgt: wgt_mem[wa]});
      end
      exp_q.push_back('{fin: 1'b1, ifm: 32'h0, wgt: 32'h0});
    end
  endtask

  task automatic check_all_zero(string name);
    chk(name, {ifm_rd_en, wgt_rd_en, ifm_rd_addr, wgt_rd_addr, PE_en, PE_finish, busy, done}, 0);
    chk({name, "_operands"}, {IFM1, IFM2, IFM3, IFM4, Weight1, Weight2, Weight3, Weight4}, 0);
  endtask

  task automatic recover();
    @(negedge clk); reset_n = 1'b1; start = 1'b0; ofm_valid = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    addr_q.delete(); exp_q.delete();
  endtask

  // Driver; cycle t of each output counts from the cycle that accepted start/ofm_valid.
  task automatic run_job(int ib, int wb, int g, int n, int stall, bit stray);
    int t;
    @(negedge clk);
    ifm_base = ADDR_W'(ib); wgt_base = ADDR_W'(wb);
    num_groups = CNT_W'(g); num_outputs = CNT_W'(n); start = 1'b1;
    if (g > 0 && n > 0) push_job(ib, wb, g, n);
    @(negedge clk);
    start = 1'b0;
    if (g == 0 || n == 0) begin
      chk("zero_done", {done, busy}, 2'b10);
      repeat (3) begin
        @(negedge clk);
        chk("zero_idle", {busy, done, ifm_rd_en}, 0);
      end
      return;
    end
    chk("busy_rise", busy, 1);
    for (int o = 0; o < n; o++) begin
      chk("read_start", ifm_rd_en, 1);
      t = 1;
      while (!PE_finish && t < g + 12) begin
        if (stray && o == 0 && t == 1) begin
          start = 1'b1; ofm_valid = 1'b1;
          ifm_base = ADDR_W'(ib + 7); num_groups = CNT_W'(g + 1);
        end
        @(negedge clk);
        t++;
        start = 1'b0; ofm_valid = 1'b0;
      end
      chk("finish_time", t, g + 3);
      if (!PE_finish) begin
        recover();
        return;
      end
      repeat (stall) begin
        @(negedge clk);
        chk("stall_quiet", {ifm_rd_en, PE_en, PE_finish, busy}, 4'b0001);
      end
      @(negedge clk);
      chk("wait_quiet", {ifm_rd_en, PE_en, PE_finish, busy, done}, 5'b00010);
      ofm_valid = 1'b1;
      @(negedge clk);
      ofm_valid = 1'b0;
      if (o == n - 1) chk("done_and_idle", {done, busy}, 2'b10);
      else            chk("no_early_done", done, 0);
    end
    @(negedge clk);
    chk("done_one_cycle", {done, busy}, 0);
    chk("addr_q_drained", addr_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ifm_mem[i] = $urandom;
      wgt_mem[i] = $urandom;
    end
    ifm_mem[0] = 32'h05040302;
    wgt_mem[0] = 32'h04030201;
    reset_n = 1'b1; start = 1'b0; ofm_valid = 1'b0;
    ifm_base = '0; wgt_base = '0; num_groups = '0; num_outputs = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset_n = 1'b0;

    run_job(0, 0, 1, 1, 1, 1'b0);        // single output, valid 2 cycles after finish
    run_job(10, 100, 3, 2, 0, 1'b0);     // multi-group, back-to-back minimum period
    run_job(200, 300, 2, 2, 20, 1'b0);   // long ofm_valid stall
    run_job(5, 5, 0, 4, 0, 1'b0);        // G = 0
    run_job(5, 5, 3, 0, 0, 1'b0);        // N = 0
    run_job(1022, 1021, 4, 1, 0, 1'b0);  // address wrap
    run_job(40, 60, 3, 2, 1, 1'b1);      // stray start/ofm_valid in READ

    // Reset during READ of output 0.
    @(negedge clk);
    ifm_base = 10'd500; wgt_base = 10'd600; num_groups = 8'd5; num_outputs = 8'd2; start = 1'b1;
    push_job(500, 600, 5, 2);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_reset_in_read", {ifm_rd_en, busy}, 2'b11);
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset_n = 1'b0;
    addr_q.delete(); exp_q.delete();
    repeat (12) begin
      @(negedge clk);
      chk("post_reset_quiet", {PE_finish, done, busy, ifm_rd_en}, 0);
    end

    for (int j = 0; j < 8; j++)
      run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
              $urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 4), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/quad_pe_feeder.md
# quad_pe_feeder

Sequencer directly upstream of the Quad_PE cluster element. On a `start` pulse it reads packed 4-channel IFM and weight words from two synchronous on-chip buffers, unpacks them onto the PE's `IFM1..4` and `Weight1..4` inputs with `PE_en`, then closes each dot product with a one-cycle `PE_finish`. It waits for the PE's `valid` before starting the next output pixel, and repeats for `num_outputs` pixels per job.

## Interface
Parameters:
- `DATA_W`, 8, width of one IFM/weight element.
- `ADDR_W`, 10, buffer address width.
- `CNT_W`, 8, width of the `num_groups` and `num_outputs` fields.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset_n`  in  1  reset. Synchronous and active-high: asserted `1` resets the block at the next edge. The port name is shared with the PE cluster.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `ifm_base`  in  `ADDR_W`  IFM word address of output 0.
- `wgt_base`  in  `ADDR_W`  weight word address; the same weights are reused for every output.
- `num_groups`  in  `CNT_W`  4-element groups per dot product (G).
- `num_outputs`  in  `CNT_W`  output pixels per job (N).
- `ifm_rd_en`, `wgt_rd_en`  out  1  buffer read strobes.
- `ifm_rd_addr`, `wgt_rd_addr`  out  `ADDR_W`  read addresses.
- `ifm_rd_data`, `wgt_rd_data`  in  `4*DATA_W`  read data, valid the cycle after the strobe. Element 1 is in the LSBs.
- `IFM1..IFM4`, `Weight1..Weight4`  out  `DATA_W`  registered PE operands.
- `PE_en`  out  1  operands valid; the PE accumulates.
- `PE_finish`  out  1  one-cycle end-of-dot-product pulse.
- `ofm_valid`  in  1  PE `valid`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle job-complete pulse.

## Operation
- States: IDLE, READ, DRAIN, FINISH, WAIT_OFM.
- **IDLE**
  - `start`=1 with G>0 and N>0: latch `ifm_base`, `wgt_base`, G and N, clear the output counter, go to READ.
  - `start`=1 with G=0 or N=0: issue no reads, pulse `done` the next cycle, stay in IDLE.
- **READ** (exactly G cycles)
  - Assert both `rd_en` strobes.
  - `wgt_rd_addr` = `wgt_base` + k.
  - `ifm_rd_addr` = `ifm_base` + o·G + k, where k is the group index (0..G-1) and o is the output index.
  - Addresses are computed modulo 2^`ADDR_W` (wrap, no error).
- **Operand pipeline**
  - Read data is registered into `IFMn`/`Weightn`.
  - `IFMn` = `ifm_rd_data[n*DATA_W-1 -: DATA_W]`; `Weightn` is packed the same way.
  - `PE_en` is the read strobe delayed 2 cycles.
  - When `PE_en`=0, all operand outputs are 0.
- **DRAIN**: 2 cycles, no reads; the pipeline empties.
- **FINISH**: 1 cycle; `PE_finish`=1.
- **WAIT_OFM**: hold until `ofm_valid`=1.
  - If outputs remain: increment o and go to READ.
  - Otherwise: `done`=1 for one cycle and go to IDLE.
- `ofm_valid` outside WAIT_OFM is ignored.
- `start` outside IDLE is ignored; latched parameters stay fixed for the whole job.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values:
  - State IDLE, all counters 0.
  - Every output 0: strobes, addresses, operands, `PE_en`, `PE_finish`, `busy`, `done`.
- `reset_n`=1 mid-job aborts at the next edge:
  - All outputs return to 0.
  - No `PE_finish` or `done` is produced.
- Per-output timeline, with `start` (or the accepting `ofm_valid`) sampled in cycle 0:
  - READ in cycles 1..G.
  - `PE_en` in cycles 3..G+2, carrying the data of addresses k=0..G-1 in order.
  - DRAIN in cycles G+1..G+2.
  - `PE_finish` in cycle G+3.
  - WAIT_OFM from cycle G+4.
- `PE_en` and `PE_finish` are never high in the same cycle.
- `PE_finish` always directly follows the last `PE_en` cycle.
- `ofm_valid` seen in cycle v:
  - If outputs remain, the next READ starts in cycle v+1.
  - Otherwise `done` is high and `busy` is low in cycle v+1.
- `ofm_valid` already high in cycle G+4 is accepted in that cycle; the minimum output period is G+4 cycles.
- `busy` rises the cycle after the accepting `start` and falls in the `done` cycle.

## Test plan
- **Single output, no stall.** `reset_n` 1→0, then `start` with G=1, N=1, `ifm_base`=0, IFM word 0x05040302, weight word 0x04030201; `ofm_valid` driven 2 cycles after `PE_finish`.
  - Required: `PE_en` in cycle 3 with IFM=2,3,4,5 and Weight=1,2,3,4.
  - Required: `PE_finish` in cycle 4.
  - Required: `done` 3 cycles after `PE_finish`.
- **Multi-group, multi-output.** G=3, N=2, `ifm_base`=10, `wgt_base`=100.
  - Required IFM addresses: 10,11,12 then 13,14,15.
  - Required weight addresses: 100,101,102 twice.
  - Required: exactly 3 `PE_en` cycles per output, 2 `PE_finish` pulses, 1 `done`.
- **Stall on `ofm_valid`.** Hold `ofm_valid` low for 20 cycles after `PE_finish`.
  - Required: no reads, no `PE_en`, `busy`=1 throughout.
  - Required: next READ exactly 1 cycle after `ofm_valid`.
- **Zero-length job.** `start` with G=0 (N=4), and separately with N=0.
  - Required: no `rd_en` at any point.
  - Required: `done` the next cycle with `busy` never high.
- **Address wrap.** `ADDR_W`=10, `ifm_base`=1022, G=4.
  - Required IFM addresses: 1022, 1023, 0, 1.
- **Reset and stray inputs.** Assert `reset_n`=1 during READ of output 0; separately pulse `start` while busy and `ofm_valid` while in READ.
  - Required on reset: all outputs 0 at the next edge, no `PE_finish`, state IDLE.
  - Required on stray pulses: both ignored, address sequence unchanged.
